// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift right, shift left or parallel load on one WIDTH-bit register.
// Latency: register updates on the clk edge after the command; qout/qb/pout are read from registers.
// Backpressure: none. en=0 or mode=00 freezes all state and suppresses word_done.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   en        operation enable
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d         serial data in
//   pdata     parallel load data
//   qout      serial data out, taken from the end selected by the last shift direction
//   qb        ~qout
//   pout      register contents
//   bit_cnt   shifts completed in the current word, 0..WIDTH-1
//   word_done one-cycle pulse after every WIDTH-th shift
//
// WIDTH must be at least 2.
module shift_reg_universal #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  localparam int                CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             d,
  input  logic [WIDTH-1:0] pdata,
  output logic             qout,
  output logic             qb,
  output logic [WIDTH-1:0] pout,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] sreg;
  // 0 = last shift was right (qout = sreg[0]), 1 = last shift was left (qout = sreg[WIDTH-1]).
  logic             dir;

  // The shift that takes bit_cnt from WIDTH-1 back to 0 completes a word.
  logic             cnt_wrap;
  logic [CW-1:0]    cnt_next;

  assign cnt_wrap = (bit_cnt == CW'(WIDTH - 1));
  assign cnt_next = cnt_wrap ? '0 : bit_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg      <= RESET_VAL;
      dir       <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (en) begin
        case (mode)
          2'b01: begin
            sreg      <= {d, sreg[WIDTH-1:1]};
            dir       <= 1'b0;
            bit_cnt   <= cnt_next;
            word_done <= cnt_wrap;
          end
          2'b10: begin
            sreg      <= {sreg[WIDTH-2:0], d};
            dir       <= 1'b1;
            bit_cnt   <= cnt_next;
            word_done <= cnt_wrap;
          end
          2'b11: begin
            // A load starts a fresh word; direction is kept so the
            // next bit presented comes from the same end as before.
            sreg    <= pdata;
            bit_cnt <= '0;
          end
          default: begin
            // Hold, including unknown mode values.
          end
        endcase
      end
    end
  end

  assign pout = sreg;
  assign qout = dir ? sreg[WIDTH-1] : sreg[0];
  assign qb   = ~qout;

endmodule
